// File: rtl/fitness_eval_if.sv
// Handshake bundle for fitness_eval_pipe: one individual in, one scored result out.
// The slave side is the evaluator; the master side is whoever feeds and drains it.
interface fitness_eval_if #(
   parameter int DATA_WIDTH     = 4,
   parameter int LATTICE_LENGTH = 11,
   parameter int IDX_WIDTH      = 6
);
   localparam int ENERGY_WIDTH = DATA_WIDTH + 2 + $clog2(LATTICE_LENGTH);

   logic                             in_valid_i;
   logic                             in_ready_o;
   logic [IDX_WIDTH-1:0]             ind_idx_i;
   logic [LATTICE_LENGTH*DATA_WIDTH-1:0] individual_vec_i;

   logic                             out_valid_o;
   logic                             out_ready_i;
   logic [ENERGY_WIDTH-1:0]          total_energy_o;
   logic [IDX_WIDTH-1:0]             ind_idx_o;
   logic                             code_err_o;
   logic                             done_o;
   logic [ENERGY_WIDTH-1:0]          best_energy_o;
   logic [IDX_WIDTH-1:0]             best_idx_o;

   modport slave (
      input  in_valid_i, ind_idx_i, individual_vec_i, out_ready_i,
      output in_ready_o, out_valid_o, total_energy_o, ind_idx_o,
             code_err_o, done_o, best_energy_o, best_idx_o
   );

   modport master (
      output in_valid_i, ind_idx_i, individual_vec_i, out_ready_i,
      input  in_ready_o, out_valid_o, total_energy_o, ind_idx_o,
             code_err_o, done_o, best_energy_o, best_idx_o
   );
endinterface

// File: rtl/fitness_eval_pipe.sv
// fitness_eval_pipe: 3-stage lattice energy evaluator (lookup, adder tree, final sum).
// Define FITNESS_BEST_TRACK_EN to add the per-generation minimum-energy tracker.
module fitness_eval_pipe #(
   parameter int NUM_PARTICLE_TYPE = 3,
   parameter int DATA_WIDTH        = 4,
   parameter int LATTICE_LENGTH    = 11,
   parameter int POP_SIZE          = 50,
   parameter int IDX_WIDTH         = 6,
   parameter int PERIODIC          = 0
) (
   input  logic                                                 clk_i,
   input  logic                                                 rst_i,
   input  logic                                                 wr_initial_i,
   input  logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]              self_energy_vec_i,
   input  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] interact_matrix_i,
   fitness_eval_if.slave                                        bus
);

   localparam int ENERGY_WIDTH = DATA_WIDTH + 2 + $clog2(LATTICE_LENGTH);
   localparam int BOND_W       = DATA_WIDTH + 1;
   localparam int CNT_W        = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;

   function automatic logic code_ok(input logic [DATA_WIDTH-1:0] code);
      return int'(code) < NUM_PARTICLE_TYPE;
   endfunction

   logic [DATA_WIDTH-1:0] se_q [NUM_PARTICLE_TYPE];
   logic [DATA_WIDTH-1:0] im_q [NUM_PARTICLE_TYPE][NUM_PARTICLE_TYPE];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_PARTICLE_TYPE; k++) begin
            se_q[k] <= '0;
            for (int j = 0; j < NUM_PARTICLE_TYPE; j++) im_q[k][j] <= '0;
         end
      end else if (wr_initial_i) begin
         for (int k = 0; k < NUM_PARTICLE_TYPE; k++) begin
            se_q[k] <= self_energy_vec_i[k*DATA_WIDTH +: DATA_WIDTH];
            for (int j = 0; j < NUM_PARTICLE_TYPE; j++)
               im_q[k][j] <= interact_matrix_i[(k*NUM_PARTICLE_TYPE+j)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   logic stall;
   logic accept;
   logic fire;
   logic vld_p0, vld_p1, vld_p2;

   assign stall          = vld_p2 && !bus.out_ready_i;
   assign bus.in_ready_o = !rst_i && !wr_initial_i && !stall;
   assign accept         = bus.in_valid_i && bus.in_ready_o;
   assign fire           = vld_p2 && bus.out_ready_i;

   // Lookup: a code outside the table matches no entry, so it contributes 0 everywhere.
   logic [DATA_WIDTH-1:0] code_c [LATTICE_LENGTH];
   logic [DATA_WIDTH-1:0] se_c   [LATTICE_LENGTH];
   logic [BOND_W-1:0]     bond_c [LATTICE_LENGTH];
   logic                  err_c;

   always_comb begin
      err_c = 1'b0;
      for (int s = 0; s < LATTICE_LENGTH; s++) begin
         code_c[s] = bus.individual_vec_i[s*DATA_WIDTH +: DATA_WIDTH];
         se_c[s]   = '0;
         err_c     = err_c | !code_ok(code_c[s]);
         for (int k = 0; k < NUM_PARTICLE_TYPE; k++)
            if (code_c[s] == DATA_WIDTH'(k)) se_c[s] = se_q[k];
      end
   end

   always_comb begin
      for (int s = 0; s < LATTICE_LENGTH; s++) begin
         bond_c[s] = '0;
         if (s < LATTICE_LENGTH-1 || PERIODIC != 0) begin
            for (int i = 0; i < NUM_PARTICLE_TYPE; i++)
               for (int j = 0; j < NUM_PARTICLE_TYPE; j++)
                  if (code_c[s] == DATA_WIDTH'(i) &&
                      code_c[(s+1) % LATTICE_LENGTH] == DATA_WIDTH'(j))
                     bond_c[s] = {im_q[i][j], 1'b0};
         end
      end
   end

   logic [DATA_WIDTH-1:0] se_p0   [LATTICE_LENGTH];
   logic [BOND_W-1:0]     bond_p0 [LATTICE_LENGTH];
   logic                  err_p0;
   logic [IDX_WIDTH-1:0]  idx_p0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p0  <= 1'b0;
         err_p0  <= 1'b0;
         idx_p0  <= '0;
         se_p0   <= '{default: '0};
         bond_p0 <= '{default: '0};
      end else if (!stall) begin
         vld_p0  <= accept;
         err_p0  <= err_c;
         idx_p0  <= bus.ind_idx_i;
         se_p0   <= se_c;
         bond_p0 <= bond_c;
      end
   end

   // Adder tree: self and bond terms reduced separately, joined in the last stage.
   logic [ENERGY_WIDTH-1:0] se_sum_c, bond_sum_c;

   always_comb begin
      se_sum_c   = '0;
      bond_sum_c = '0;
      for (int s = 0; s < LATTICE_LENGTH; s++) begin
         se_sum_c   = se_sum_c + ENERGY_WIDTH'(se_p0[s]);
         bond_sum_c = bond_sum_c + ENERGY_WIDTH'(bond_p0[s]);
      end
   end

   logic [ENERGY_WIDTH-1:0] se_sum_p1, bond_sum_p1;
   logic                    err_p1;
   logic [IDX_WIDTH-1:0]    idx_p1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p1      <= 1'b0;
         err_p1      <= 1'b0;
         idx_p1      <= '0;
         se_sum_p1   <= '0;
         bond_sum_p1 <= '0;
      end else if (!stall) begin
         vld_p1      <= vld_p0;
         err_p1      <= err_p0;
         idx_p1      <= idx_p0;
         se_sum_p1   <= se_sum_c;
         bond_sum_p1 <= bond_sum_c;
      end
   end

   // Final sum and output register.
   logic [ENERGY_WIDTH-1:0] energy_p2;
   logic                    err_p2;
   logic [IDX_WIDTH-1:0]    idx_p2;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p2    <= 1'b0;
         err_p2    <= 1'b0;
         idx_p2    <= '0;
         energy_p2 <= '0;
      end else if (!stall) begin
         vld_p2    <= vld_p1;
         err_p2    <= err_p1;
         idx_p2    <= idx_p1;
         energy_p2 <= se_sum_p1 + bond_sum_p1;
      end
   end

   assign bus.out_valid_o    = vld_p2;
   assign bus.total_energy_o = energy_p2;
   assign bus.ind_idx_o      = idx_p2;
   assign bus.code_err_o     = err_p2;

   logic [CNT_W-1:0] gen_cnt;
   logic             gen_last;

   assign gen_last   = (gen_cnt == CNT_W'(POP_SIZE-1));
   assign bus.done_o = fire && gen_last && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i)     gen_cnt <= '0;
      else if (fire) gen_cnt <= gen_last ? '0 : gen_cnt + 1'b1;
   end

`ifdef FITNESS_BEST_TRACK_EN
   logic [ENERGY_WIDTH-1:0] best_energy_q;
   logic [IDX_WIDTH-1:0]    best_idx_q;

   // Strict less-than keeps the earliest individual on ties; count 0 starts a new generation.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         best_energy_q <= '0;
         best_idx_q    <= '0;
      end else if (fire && (gen_cnt == '0 || energy_p2 < best_energy_q)) begin
         best_energy_q <= energy_p2;
         best_idx_q    <= idx_p2;
      end
   end

   assign bus.best_energy_o = best_energy_q;
   assign bus.best_idx_o    = best_idx_q;
`else
   assign bus.best_energy_o = '0;
   assign bus.best_idx_o    = '0;
`endif

endmodule

// File: tb/tb_fitness_eval_pipe.sv
// Bench for fitness_eval_pipe: two instances (open and periodic lattice) share one stimulus
// stream; a queue-based energy model is compared on every output handshake.
module tb_fitness_eval_pipe;
   localparam int NPT = 3;
   localparam int DW  = 4;
   localparam int L   = 11;
   localparam int POP = 50;
   localparam int IW  = 6;
   localparam int EW  = DW + 2 + $clog2(L);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst, wr_initial, in_valid, out_ready;
   logic [NPT*DW-1:0]    se_vec;
   logic [NPT*NPT*DW-1:0] im_vec;
   logic [L*DW-1:0]      indiv;
   logic [IW-1:0]        idx;

   int errors = 0;
   int checks = 0;

   fitness_eval_if #(.DATA_WIDTH(DW), .LATTICE_LENGTH(L), .IDX_WIDTH(IW)) if0 ();
   fitness_eval_if #(.DATA_WIDTH(DW), .LATTICE_LENGTH(L), .IDX_WIDTH(IW)) if1 ();

   assign if0.in_valid_i = in_valid;       assign if1.in_valid_i = in_valid;
   assign if0.ind_idx_i = idx;             assign if1.ind_idx_i = idx;
   assign if0.individual_vec_i = indiv;    assign if1.individual_vec_i = indiv;
   assign if0.out_ready_i = out_ready;     assign if1.out_ready_i = out_ready;

   fitness_eval_pipe #(.NUM_PARTICLE_TYPE(NPT), .DATA_WIDTH(DW), .LATTICE_LENGTH(L),
                       .POP_SIZE(POP), .IDX_WIDTH(IW), .PERIODIC(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .wr_initial_i(wr_initial),
      .self_energy_vec_i(se_vec), .interact_matrix_i(im_vec), .bus(if0.slave));

   fitness_eval_pipe #(.NUM_PARTICLE_TYPE(NPT), .DATA_WIDTH(DW), .LATTICE_LENGTH(L),
                       .POP_SIZE(POP), .IDX_WIDTH(IW), .PERIODIC(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .wr_initial_i(wr_initial),
      .self_energy_vec_i(se_vec), .interact_matrix_i(im_vec), .bus(if1.slave));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model state: coefficient copies, expected-result queue, generation count and minimums.
   int se_m [NPT];
   int im_m [NPT][NPT];

   typedef struct packed {
      logic [31:0]   e0;
      logic [31:0]   e1;
      logic [IW-1:0] tag;
      logic          err;
   } exp_t;

   exp_t q[$];
   int   m_cnt = 0;
   int   m_best_e0 = 0, m_best_i0 = 0, m_best_e1 = 0, m_best_i1 = 0;
   int   done_seen = 0;

   function automatic int model_energy(input logic [L*DW-1:0] v, input bit per);
      int c [L];
      int e;
      e = 0;
      for (int s = 0; s < L; s++) c[s] = int'(v[s*DW +: DW]);
      for (int s = 0; s < L; s++) if (c[s] < NPT) e += se_m[c[s]];
      for (int s = 0; s < L-1; s++)
         if (c[s] < NPT && c[s+1] < NPT) e += 2 * im_m[c[s]][c[s+1]];
      if (per && c[L-1] < NPT && c[0] < NPT) e += 2 * im_m[c[L-1]][c[0]];
      return e;
   endfunction

   function automatic bit model_err(input logic [L*DW-1:0] v);
      bit b;
      b = 1'b0;
      for (int s = 0; s < L; s++) if (int'(v[s*DW +: DW]) >= NPT) b = 1'b1;
      return b;
   endfunction

   function automatic logic [L*DW-1:0] fill(input int code);
      logic [L*DW-1:0] v;
      for (int s = 0; s < L; s++) v[s*DW +: DW] = DW'(code);
      return v;
   endfunction

   function automatic logic [L*DW-1:0] gen_ind(input int t);
      logic [L*DW-1:0] v;
      v = fill(0);
      if (t != 17 && t != 30) v[(t % L)*DW +: DW] = DW'(1 + (t % 2));
      return v;
   endfunction

   logic          prev_rst = 1'b1;
   logic          prev_stall = 1'b0;
   logic [EW-1:0] hold_e0, hold_e1;
   logic [IW-1:0] hold_i;
   logic          hold_err;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         check("in_ready_during_reset", {if1.in_ready_o, if0.in_ready_o}, 2'b00);
         q.delete();
         m_cnt = 0;
         m_best_e0 = 0; m_best_i0 = 0; m_best_e1 = 0; m_best_i1 = 0;
         for (int k = 0; k < NPT; k++) begin
            se_m[k] = 0;
            for (int j = 0; j < NPT; j++) im_m[k][j] = 0;
         end
         prev_stall = 1'b0;
         prev_rst   = 1'b1;
      end else begin
         if (prev_rst) begin
            check("post_reset_out_valid", {if1.out_valid_o, if0.out_valid_o}, 2'b00);
            check("post_reset_energy", if0.total_energy_o, 0);
            check("post_reset_idx", if0.ind_idx_o, 0);
            check("post_reset_err", if0.code_err_o, 0);
         end
         check("in_ready_rule", if0.in_ready_o, !wr_initial && !(if0.out_valid_o && !out_ready));
         check("out_valid_pair", if1.out_valid_o, if0.out_valid_o);
`ifdef FITNESS_BEST_TRACK_EN
         check("best_energy0", if0.best_energy_o, m_best_e0);
         check("best_idx0", if0.best_idx_o, m_best_i0);
         check("best_energy1", if1.best_energy_o, m_best_e1);
         check("best_idx1", if1.best_idx_o, m_best_i1);
`else
         check("best_energy_off", {if1.best_energy_o, if0.best_energy_o}, 0);
         check("best_idx_off", {if1.best_idx_o, if0.best_idx_o}, 0);
`endif
         if (prev_stall) begin
            check("stall_hold_energy0", if0.total_energy_o, hold_e0);
            check("stall_hold_energy1", if1.total_energy_o, hold_e1);
            check("stall_hold_idx", if0.ind_idx_o, hold_i);
            check("stall_hold_err", if0.code_err_o, hold_err);
            check("stall_hold_valid", if0.out_valid_o, 1);
         end
         if (if0.done_o) done_seen++;
         if (if0.out_valid_o && out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               e = q.pop_front();
               check("energy_open", if0.total_energy_o, e.e0);
               check("energy_periodic", if1.total_energy_o, e.e1);
               check("tag_open", if0.ind_idx_o, e.tag);
               check("tag_periodic", if1.ind_idx_o, e.tag);
               check("code_err_open", if0.code_err_o, e.err);
               check("code_err_periodic", if1.code_err_o, e.err);
               check("done_on_handshake", {if1.done_o, if0.done_o}, (m_cnt == POP-1) ? 2'b11 : 2'b00);
               if (m_cnt == 0 || int'(e.e0) < m_best_e0) begin
                  m_best_e0 = int'(e.e0); m_best_i0 = int'(e.tag);
               end
               if (m_cnt == 0 || int'(e.e1) < m_best_e1) begin
                  m_best_e1 = int'(e.e1); m_best_i1 = int'(e.tag);
               end
               m_cnt = (m_cnt == POP-1) ? 0 : m_cnt + 1;
            end
         end else begin
            check("done_idle", {if1.done_o, if0.done_o}, 2'b00);
         end
         if (in_valid && if0.in_ready_o) begin
            e.e0  = 32'(model_energy(indiv, 1'b0));
            e.e1  = 32'(model_energy(indiv, 1'b1));
            e.tag = idx;
            e.err = model_err(indiv);
            q.push_back(e);
         end
         prev_stall = if0.out_valid_o && !out_ready;
         hold_e0  = if0.total_energy_o;
         hold_e1  = if1.total_energy_o;
         hold_i   = if0.ind_idx_o;
         hold_err = if0.code_err_o;
         prev_rst = 1'b0;
      end
   end

   task automatic write_coef(input int s0, input int s1, input int s2, input int imv);
      int sev [NPT];
      sev[0] = s0; sev[1] = s1; sev[2] = s2;
      for (int k = 0; k < NPT; k++) begin
         se_vec[k*DW +: DW] = DW'(sev[k]);
         se_m[k] = sev[k];
         for (int j = 0; j < NPT; j++) begin
            im_vec[(k*NPT+j)*DW +: DW] = DW'(imv);
            im_m[k][j] = imv;
         end
      end
      wr_initial = 1'b1;
      @(posedge clk); #1;
      wr_initial = 1'b0;
   endtask

   task automatic send(input logic [L*DW-1:0] v, input int t);
      int n;
      indiv = v; idx = IW'(t); in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!if0.in_ready_o && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) check("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      @(negedge clk);
      while (!if0.out_valid_o && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) check("output_timeout", 0, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((q.size() != 0 || if0.out_valid_o) && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (n >= 300) check("drain_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic [L*DW-1:0] v;
      logic [EW-1:0]   cap_e;
      rst = 1'b1; wr_initial = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      se_vec = '0; im_vec = '0; indiv = '0; idx = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_best_energy", if0.best_energy_o, 0);
      check("reset_done", if0.done_o, 0);
      @(posedge clk); #1;

      // SE={1,2,3}, IM=1, all code 0: 11 + 10*2 = 31, periodic 33; visible at the third edge after accept.
      write_coef(1, 2, 3, 1);
      check("model_pin_31", model_energy(fill(0), 1'b0), 31);
      send(fill(0), 5);
      @(negedge clk); check("latency_T1_valid", if0.out_valid_o, 0);
      @(negedge clk); check("latency_T2_valid", if0.out_valid_o, 0);
      @(negedge clk); check("latency_T3_valid", if0.out_valid_o, 1);
      check("energy_all0_open", if0.total_energy_o, 31);
      check("energy_all0_periodic", if1.total_energy_o, 33);
      check("tag_all0", if0.ind_idx_o, 5);
      drain();

      // All coefficients 15, all code 2: 165 + 300 = 465, periodic 495.
      write_coef(15, 15, 15, 15);
      send(fill(2), 6);
      wait_out();
      check("energy_max_open", if0.total_energy_o, 465);
      check("energy_max_periodic", if1.total_energy_o, 495);
      check("err_max", if0.code_err_o, 0);
      drain();

      // Site 4 invalid: 10 selfs + 8 bonds*2 = 26, periodic 28.
      write_coef(1, 2, 3, 1);
      v = fill(0);
      v[4*DW +: DW] = DW'(3);
      check("model_pin_26", model_energy(v, 1'b0), 26);
      send(v, 7);
      wait_out();
      check("energy_bad_open", if0.total_energy_o, 26);
      check("energy_bad_periodic", if1.total_energy_o, 28);
      check("code_err_bad", if0.code_err_o, 1);
      drain();

      // Back-to-back with the consumer stalled for 5 cycles; first result is all code 1 = 42.
      out_ready = 1'b0;
      fork
         begin
            send(fill(1), 10);
            send(fill(2), 11);
            send(gen_ind(3), 12);
            send(gen_ind(4), 13);
         end
         begin
            wait_out();
            cap_e = if0.total_energy_o;
            check("stall_first_energy", cap_e, 42);
            check("stall_first_tag", if0.ind_idx_o, 10);
            for (int k = 0; k < 5; k++) begin
               check("stall_in_ready", if0.in_ready_o, 0);
               check("stall_energy_stable", if0.total_energy_o, cap_e);
               @(negedge clk);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Full generation: tags 0..49, 17 and 30 tie at the minimum 31, earliest wins.
      pulse_reset(2);
      write_coef(1, 2, 3, 1);
      done_seen = 0;
      for (int t = 0; t < POP; t++) send(gen_ind(t), t);
      drain();
      check("gen_done_count", done_seen, 1);
`ifdef FITNESS_BEST_TRACK_EN
      check("gen_best_idx", if0.best_idx_o, 17);
      check("gen_best_energy", if0.best_energy_o, 31);
      check("gen_best_energy_periodic", if1.best_energy_o, 33);
`else
      check("gen_best_idx_off", if0.best_idx_o, 0);
`endif

      // Mid-flight reset: 3 completed, 2 in flight, then a fresh generation counted from 1.
      for (int t = 1; t <= 3; t++) send(gen_ind(t), t);
      drain();
      send(fill(1), 4);
      send(fill(2), 5);
      pulse_reset(1);
      @(negedge clk);
      check("midreset_out_valid", {if1.out_valid_o, if0.out_valid_o}, 2'b00);
      @(posedge clk); #1;
      write_coef(1, 2, 3, 1);
      done_seen = 0;
      for (int t = 0; t < POP; t++) send(gen_ind(t), t);
      drain();
      check("post_reset_done_count", done_seen, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end
endmodule
